// File: rtl/afpm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : afpm_pkg
// Brief    : Shared types and default constants for the AFPM byte-serial host.
// Revision : 1.0 - initial release
// ============================================================================
package afpm_pkg;

  localparam logic [7:0] AFPM_START_BYTE     = 8'h01;
  localparam int         AFPM_PROC_CYCLES    = 6;
  localparam int         AFPM_DUT_RST_CYCLES = 2;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int FP_W  = 1 + EXP_W + MAN_W;

  typedef enum logic [3:0] {
    RST_HOLD = 4'd0,
    IDLE     = 4'd1,
    START    = 4'd2,
    SEND_LO  = 4'd3,
    SEND_HI  = 4'd4,
    WAIT     = 4'd5,
    CAP_LO   = 4'd6,
    CAP_HI   = 4'd7,
    HOLD     = 4'd8
  } afpm_state_e;

endpackage : afpm_pkg
`default_nettype wire

// File: rtl/afpm_byte_host.sv
`default_nettype none
// ============================================================================
// Module   : afpm_byte_host
// Brief    : Host-side initiator for the logarithmic FP16 multiplier's
//            byte-serial pin protocol. Optional macro AFPM_TXN_COUNT_EN adds
//            a 16-bit completed-transaction counter port.
// Revision : 1.0 - initial release
// ============================================================================
module afpm_byte_host
  import afpm_pkg::*;
#(
  parameter logic [7:0] START_BYTE     = AFPM_START_BYTE,
  parameter int         PROC_CYCLES    = AFPM_PROC_CYCLES,
  parameter int         DUT_RST_CYCLES = AFPM_DUT_RST_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] op_a,
  input  logic [FP_W-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] result,
  output logic            busy,
  output logic            dut_rst_n,
  output logic [7:0]      dut_ui,
  output logic [7:0]      dut_uio,
  input  logic [7:0]      dut_uo
`ifdef AFPM_TXN_COUNT_EN
  ,
  output logic [15:0]     txn_count
`endif
);

  localparam int WAIT_W = $clog2(PROC_CYCLES + 2);
  localparam int RST_W  = $clog2(DUT_RST_CYCLES + 2);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(PROC_CYCLES);
  localparam logic [RST_W-1:0]  RST_DONE  = RST_W'(DUT_RST_CYCLES);

  // A zero start byte would be indistinguishable from the idle bus.
  generate
    if (START_BYTE == 8'h00) begin : g_bad_start_byte
      $error("afpm_byte_host: START_BYTE must be nonzero");
    end
  endgenerate

  afpm_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [FP_W-1:0]   op_a_q, op_a_d;
  logic [FP_W-1:0]   op_b_q, op_b_d;
  logic [FP_W-1:0]   result_q, result_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_HOLD;
      wait_cnt_q <= '0;
      rst_cnt_q  <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rst_cnt_q  <= rst_cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      result_q   <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    rst_cnt_d  = rst_cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    result_d   = result_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    dut_rst_n  = 1'b1;
    dut_ui     = 8'h00;
    dut_uio    = 8'h00;

    case (state_q)
      RST_HOLD: begin
        // Release the multiplier one cycle before accepting work so its
        // synchronous reset is out of the way before the first START.
        dut_rst_n = (rst_cnt_q >= RST_DONE);
        if (rst_cnt_q == RST_DONE) begin
          state_d = IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_a_d  = op_a;
          op_b_d  = op_b;
          state_d = START;
        end
      end
      START: begin
        dut_ui  = START_BYTE;
        state_d = SEND_LO;
      end
      SEND_LO: begin
        dut_ui  = op_a_q[7:0];
        dut_uio = op_b_q[7:0];
        state_d = SEND_HI;
      end
      SEND_HI: begin
        dut_ui     = op_a_q[15:8];
        dut_uio    = op_b_q[15:8];
        wait_cnt_d = WAIT_LOAD;
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = CAP_LO;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      CAP_LO: begin
        result_d[7:0] = dut_uo;
        state_d       = CAP_HI;
      end
      CAP_HI: begin
        result_d[15:8] = dut_uo;
        state_d        = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = RST_HOLD;
      end
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign result = result_q;

`ifdef AFPM_TXN_COUNT_EN
  logic [15:0] txn_count_q, txn_count_d;

  always_comb begin
    txn_count_d = txn_count_q;
    if (out_valid && out_ready) begin
      txn_count_d = txn_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count_q <= 16'd0;
    end else begin
      txn_count_q <= txn_count_d;
    end
  end

  assign txn_count = txn_count_q;
`endif

endmodule : afpm_byte_host
`default_nettype wire

// File: tb/tb_afpm_byte_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_afpm_byte_host
// Brief    : Directed bench for afpm_byte_host with a cycle-accurate
//            byte-serial multiplier model and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_afpm_byte_host;

  localparam int P = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        busy;
  logic        dut_rst_n;
  logic [7:0]  dut_ui;
  logic [7:0]  dut_uio;
  logic [7:0]  dut_uo;
`ifdef AFPM_TXN_COUNT_EN
  logic [15:0] txn_count;
`endif

  int errors = 0;
  int checks = 0;
  int txn_exp = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  afpm_byte_host dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy),
    .dut_rst_n (dut_rst_n),
    .dut_ui    (dut_ui),
    .dut_uio   (dut_uio),
    .dut_uo    (dut_uo)
`ifdef AFPM_TXN_COUNT_EN
    ,
    .txn_count (txn_count)
`endif
  );

  // Multiplier model: bias-subtracting log approximation, registered uo_out
  // that idles at A5 so a mistimed capture is visible.
  localparam logic [2:0] M_IDLE = 3'd0, M_LO = 3'd1, M_HI = 3'd2,
                         M_PROC = 3'd3, M_OUT_LO = 3'd4, M_OUT_HI = 3'd5;
  logic [2:0]  m_st;
  logic [15:0] m_a, m_b, m_p;
  int          m_cnt;
  logic [7:0]  m_uo;

  assign m_p    = {m_a[15] ^ m_b[15], m_a[14:0] + m_b[14:0] - 15'h3C00};
  assign dut_uo = m_uo;

  always @(posedge clk) begin
    if (!dut_rst_n) begin
      m_st <= M_IDLE;
      m_uo <= 8'hA5;
      m_cnt <= 0;
    end else begin
      case (m_st)
        M_IDLE:   begin m_uo <= 8'hA5; if (dut_ui != 8'h00) m_st <= M_LO; end
        M_LO:     begin m_a[7:0] <= dut_ui; m_b[7:0] <= dut_uio; m_st <= M_HI; end
        M_HI:     begin m_a[15:8] <= dut_ui; m_b[15:8] <= dut_uio; m_cnt <= P; m_st <= M_PROC; end
        M_PROC:   begin if (m_cnt == 1) m_st <= M_OUT_LO; else m_cnt <= m_cnt - 1; end
        M_OUT_LO: begin m_uo <= m_p[7:0]; m_st <= M_OUT_HI; end
        M_OUT_HI: begin m_uo <= m_p[15:8]; m_st <= M_IDLE; end
        default:  m_st <= M_IDLE;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Deassert rst just after an edge and measure the multiplier reset pulse.
  task automatic rst_release();
    int lows = 0;
    int bus_nz = 0;
    int ov = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    while (!dut_rst_n && lows < 20) begin
      lows++;
      if (dut_ui != 0 || dut_uio != 0) bus_nz++;
      if (out_valid) ov++;
      @(negedge clk);
    end
    chk("rst_n_low_cycles", lows, 2);
    chk("rst_bus_zero", bus_nz, 0);
    chk("rst_no_out_valid", ov, 0);
    chk("in_ready_at_rst_n_rise", in_ready, 1'b0);
    @(negedge clk);
    chk("in_ready_after_rst_n", in_ready, 1'b1);
    chk("busy_idle", busy, 1'b0);
  endtask

  // Called at a negedge; returns at the negedge where out_valid first shows.
  task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    int n = 0;
    int lat;
    int bus_nz = 0;
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    sb.push_back(exp);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_seen", in_ready, 1'b1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    lat = 1;
    chk("start_ui", dut_ui, 8'h01);
    chk("start_uio", dut_uio, 8'h00);
    @(negedge clk);
    lat = 2;
    chk("send_lo", {dut_ui, dut_uio}, {a[7:0], b[7:0]});
    @(negedge clk);
    lat = 3;
    chk("send_hi", {dut_ui, dut_uio}, {a[15:8], b[15:8]});
    @(negedge clk);
    lat = 4;
    while (!out_valid && lat < 40) begin
      if (dut_ui != 0 || dut_uio != 0 || in_ready) bus_nz++;
      @(negedge clk);
      lat++;
    end
    chk("wait_bus_quiet", bus_nz, 0);
    chk("latency", lat, 13);
  endtask

  // Hold off out_ready, then score the result and accept it.
  task automatic drain(input int hold);
    logic [15:0] r0;
    logic [15:0] exp;
    int unstable = 0;
    r0 = result;
    repeat (hold) begin
      @(negedge clk);
      if (!out_valid || in_ready || result !== r0) unstable++;
    end
    chk("hold_stable", unstable, 0);
    chk("sb_nonempty", sb.size() != 0, 1);
    exp = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
    chk("result", result, exp);
    out_ready = 1'b1;
    txn_exp++;
  endtask

  task automatic back_to_idle();
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_in_ready", in_ready, 1'b1);
`ifdef AFPM_TXN_COUNT_EN
    chk("txn_count", txn_count, txn_exp[15:0]);
`endif
  endtask

  initial begin
    int ov;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 16'h0000);
    chk("rst_busy", busy, 1'b1);
    chk("rst_dut_rst_n", dut_rst_n, 1'b0);
    chk("rst_bus", {dut_ui, dut_uio}, 16'h0000);
    rst_release();

    send_pair(16'h3C00, 16'h3C00, 16'h3C00);
    drain(0);
    back_to_idle();

    send_pair(16'h3C00, 16'h4000, 16'h4000);
    drain(0);
    back_to_idle();

    send_pair(16'h4000, 16'h4200, 16'h4600);
    drain(20);
    send_pair(16'hBC00, 16'h4000, 16'hC000);
    drain(3);
    back_to_idle();

    // Reset in the middle of WAIT: the pair is dropped.
    in_valid = 1'b1;
    op_a = 16'h4400;
    op_b = 16'h4400;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b1);
    chk("midrst_dut_rst_n", dut_rst_n, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    rst_release();
    ov = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    chk("midrst_no_out_valid", ov, 0);
    chk("midrst_sb_empty", sb.size(), 0);
    txn_exp = 0;

    send_pair(16'h3C00, 16'h3C00, 16'h3C00);
    drain(0);
    back_to_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_afpm_byte_host
`default_nettype wire
